wbwalk_sched: RTL and testbench

Wishbone bus master that schedules LED-walk runs on the six-LED walker slave. It merges two start sources, a periodic timer and a user request pulse, into single-write Wishbone transactions. It holds each request through the walker's busy stall and enforces an acknowledgement timeout. It sits between the board-level trigger logic and the walker's Wishbone slave port, and exposes completion and error status to the rest of the design.

---
 rtl/wbwalk_sched.sv | 152 +++++++++++++++
 tb/tb_wbwalk_sched.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/wbwalk_sched.sv
// rtl/wbwalk_sched.sv - Wishbone master that schedules walker runs from a timer and user requests.
// Single-write transactions with stall hold, ack timeout and sticky error status.
module wbwalk_sched #(
  parameter int unsigned CLOCK_DIV = 1000000,
  parameter int unsigned TIMEOUT   = 31
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic       i_req,
  input  logic       i_clr_err,
  output logic       o_cyc,
  output logic       o_stb,
  output logic       o_we,
  output logic       o_addr,
  output logic [5:0] o_data,
  input  logic       i_stall,
  input  logic       i_ack,
  output logic       o_busy,
  output logic       o_err,
  output logic [7:0] o_count
);

  typedef enum logic [1:0] {IDLE, WR_REQ, WR_ACK} state_t;

  localparam logic [23:0] TMR_LAST = 24'(CLOCK_DIV - 1);
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [23:0] tmr_q, tmr_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        pend_usr_q, pend_usr_d;
  logic        pend_tmr_q, pend_tmr_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic [5:0]  data_q, data_d;
  logic        err_q, err_d;
  logic [7:0]  count_q, count_d;

  logic tmr_wrap;
  logic launch_usr;
  logic launch_tmr;
  logic abort;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      tmo_q      <= '0;
      pend_usr_q <= 1'b0;
      pend_tmr_q <= 1'b0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      data_q     <= '0;
      err_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      tmo_q      <= tmo_d;
      pend_usr_q <= pend_usr_d;
      pend_tmr_q <= pend_tmr_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      data_q     <= data_d;
      err_q      <= err_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    data_d     = data_q;
    count_d    = count_q;
    launch_usr = 1'b0;
    launch_tmr = 1'b0;
    abort      = 1'b0;

    tmr_wrap = i_en && (tmr_q == TMR_LAST);
    if (!i_en || tmr_wrap) begin
      tmr_d = '0;
    end else begin
      tmr_d = tmr_q + 24'd1;
    end

    case (state_q)
      IDLE: begin
        data_d = '0;
        if (pend_usr_q) begin
          launch_usr = 1'b1;
          state_d    = WR_REQ;
          data_d     = 6'h02;
          tmo_d      = '0;
        end else if (pend_tmr_q) begin
          launch_tmr = 1'b1;
          state_d    = WR_REQ;
          data_d     = 6'h01;
          tmo_d      = '0;
        end
      end
      WR_REQ: begin
        tmo_d = tmo_q + 8'd1;
        // A completing edge beats the timeout; an accept without ack does not.
        if (!i_stall && i_ack) begin
          state_d = IDLE;
          data_d  = '0;
          count_d = count_q + 8'd1;
        end else if (tmo_q == TMO_LAST) begin
          abort = 1'b1;
        end else if (!i_stall) begin
          state_d = WR_ACK;
        end
      end
      WR_ACK: begin
        tmo_d = tmo_q + 8'd1;
        if (i_ack) begin
          state_d = IDLE;
          data_d  = '0;
          count_d = count_q + 8'd1;
        end else if (tmo_q == TMO_LAST) begin
          abort = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        data_d  = '0;
      end
    endcase

    if (abort) begin
      state_d = IDLE;
      data_d  = '0;
    end

    pend_usr_d = i_req    | (pend_usr_q & ~launch_usr);
    pend_tmr_d = tmr_wrap | (pend_tmr_q & ~launch_tmr);
    err_d      = abort ? 1'b1 : (i_clr_err ? 1'b0 : err_q);
    cyc_d      = (state_d != IDLE);
    stb_d      = (state_d == WR_REQ);
  end

  assign o_cyc   = cyc_q;
  assign o_stb   = stb_q;
  assign o_we    = stb_q;
  assign o_addr  = 1'b0;
  assign o_data  = data_q;
  assign o_busy  = cyc_q;
  assign o_err   = err_q;
  assign o_count = count_q;

endmodule

// File: tb/tb_wbwalk_sched.sv
// tb/tb_wbwalk_sched.sv - Self-checking bench for wbwalk_sched.
module tb_wbwalk_sched;

  logic       clk;
  logic       rst;
  logic       en, req, clr_err, stall, ack;
  logic       cyc, stb, we, addr, busy, err;
  logic [5:0] data;
  logic [7:0] count;
  logic       auto_ack;

  int n_chk;
  int n_fail;

  wbwalk_sched #(.CLOCK_DIV(8), .TIMEOUT(31)) dut (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_req(req), .i_clr_err(clr_err),
    .o_cyc(cyc), .o_stb(stb), .o_we(we), .o_addr(addr), .o_data(data),
    .i_stall(stall), .i_ack(ack), .o_busy(busy), .o_err(err), .o_count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       req;
    logic       stall;
    logic       ack;
    logic       exp_cyc;
    logic       exp_stb;
    logic [5:0] exp_data;
    logic       exp_err;
    logic [7:0] exp_count;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input logic r, input logic s, input logic a, input logic c,
                              input logic sb, input logic [5:0] d, input logic e,
                              input logic [7:0] n);
    vec_t v;
    v.req = r; v.stall = s; v.ack = a; v.exp_cyc = c; v.exp_stb = sb;
    v.exp_data = d; v.exp_err = e; v.exp_count = n;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave stand-in: acks the cycle after the write is accepted.
  task automatic step();
    @(posedge clk);
    #1;
    if (auto_ack) ack = cyc && !stb;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 0; req = 0; clr_err = 0; stall = 0; ack = 0; auto_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int c;
    int nstb;
    logic data_ok;
    logic prev_stb;
    logic seen_cyc;
    logic wrap_ok;
    logic timed_out;
    int launch_k[$];
    logic [5:0] launch_d[$];

    n_chk = 0;
    n_fail = 0;

    // Reset state
    do_reset();
    check("reset_outputs", {cyc, stb, we, addr, busy, data, err, count}, 32'h0);

    // Basic transactions, including ack ignored in idle and accept+ack on one edge
    vecs[0]  = mk(1, 0, 0, 0, 0, 6'h00, 0, 8'd0);
    vecs[1]  = mk(0, 0, 0, 1, 1, 6'h02, 0, 8'd0);
    vecs[2]  = mk(0, 0, 0, 1, 0, 6'h02, 0, 8'd0);
    vecs[3]  = mk(0, 0, 1, 0, 0, 6'h00, 0, 8'd1);
    vecs[4]  = mk(0, 0, 1, 0, 0, 6'h00, 0, 8'd1);
    vecs[5]  = mk(0, 0, 0, 0, 0, 6'h00, 0, 8'd1);
    vecs[6]  = mk(1, 0, 0, 0, 0, 6'h00, 0, 8'd1);
    vecs[7]  = mk(0, 1, 0, 1, 1, 6'h02, 0, 8'd1);
    vecs[8]  = mk(0, 1, 0, 1, 1, 6'h02, 0, 8'd1);
    vecs[9]  = mk(0, 0, 1, 0, 0, 6'h00, 0, 8'd2);
    vecs[10] = mk(0, 0, 0, 0, 0, 6'h00, 0, 8'd2);
    for (int i = 0; i < 11; i++) begin
      req = vecs[i].req; stall = vecs[i].stall; ack = vecs[i].ack;
      step();
      check($sformatf("vec%0d", i), {13'd0, cyc, stb, we, busy, data, err, count},
            {13'd0, vecs[i].exp_cyc, vecs[i].exp_stb, vecs[i].exp_stb, vecs[i].exp_cyc,
             vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_count});
    end
    req = 0; stall = 0; ack = 0;

    // Stall held 11 cycles after strobe rises
    do_reset();
    req = 1; step(); req = 0; stall = 1; step();
    c = 0; nstb = 0; data_ok = 1;
    while (stb && c < 50) begin
      nstb++;
      if (data !== 6'h02) data_ok = 0;
      stall = (c < 11);
      c++;
      step();
    end
    check("stall_stb_cycles", nstb, 12);
    check("stall_data_stable", data_ok, 1);
    check("stall_in_wr_ack", {cyc, stb}, 2'b10);
    ack = 1; step(); ack = 0;
    check("stall_done", {cyc, err, count}, {1'b0, 1'b0, 8'd1});

    // Timeout with stall stuck, then error clear, then clear coinciding with abort
    do_reset();
    req = 1; step(); req = 0; stall = 1; step();
    n = 0;
    while (cyc && n < 100) begin n++; step(); end
    check("tmo_cyc_cycles", n, 31);
    check("tmo_state", {cyc, stb, err, count}, {1'b0, 1'b0, 1'b1, 8'd0});
    clr_err = 1; step(); clr_err = 0;
    check("tmo_clr_err", err, 0);
    req = 1; step(); req = 0; clr_err = 1; step();
    n = 0;
    while (cyc && n < 100) begin n++; step(); end
    clr_err = 0;
    check("tmo2_cyc_cycles", n, 31);
    check("tmo2_set_wins", err, 1);
    step();
    check("tmo2_err_sticky", {err, count}, {1'b1, 8'd0});
    stall = 0;

    // User request coinciding with timer wrap: user first, then timer
    do_reset();
    auto_ack = 1; en = 1; prev_stb = 0;
    for (int k = 1; k <= 15; k++) begin
      req = (k == 8);
      step();
      if (stb && !prev_stb) begin launch_k.push_back(k); launch_d.push_back(data); end
      prev_stb = stb;
    end
    req = 0;
    check("prio_launches", launch_k.size(), 2);
    if (launch_k.size() == 2) begin
      check("prio_first_data", launch_d[0], 6'h02);
      check("prio_first_edge", launch_k[0], 9);
      check("prio_second_data", launch_d[1], 6'h01);
      check("prio_second_edge", launch_k[1], 12);
    end
    check("prio_count", count, 8'd2);

    // Periodic timer transactions over 40 cycles
    do_reset();
    auto_ack = 1; en = 1; prev_stb = 0;
    launch_k.delete(); launch_d.delete();
    for (int k = 1; k <= 40; k++) begin
      step();
      if (stb && !prev_stb) begin launch_k.push_back(k); launch_d.push_back(data); end
      prev_stb = stb;
    end
    en = 0;
    check("tmr_launches", launch_k.size(), 4);
    if (launch_k.size() == 4) begin
      check("tmr_first_edge", launch_k[0], 9);
      for (int i = 1; i < 4; i++) begin
        check($sformatf("tmr_interval%0d", i), launch_k[i] - launch_k[i-1], 8);
        check($sformatf("tmr_data%0d", i), launch_d[i], 6'h01);
      end
    end
    check("tmr_count", count, 8'd4);

    // Reset in WR_ACK with timer pending
    do_reset();
    en = 1; stall = 1;
    for (int k = 1; k <= 9; k++) begin
      req = (k == 5);
      stall = (k != 9);
      step();
    end
    en = 0; stall = 0;
    check("rst_in_wr_ack", {cyc, stb}, 2'b10);
    #2 rst = 1'b1;
    #1;
    check("rst_async_cyc", {cyc, stb, busy}, 3'b000);
    @(posedge clk); #1 rst = 1'b0;
    seen_cyc = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (cyc) seen_cyc = 1;
    end
    check("rst_no_txn", seen_cyc, 0);
    check("rst_count", count, 8'd0);

    // 256 acked transactions wrap the counter
    do_reset();
    auto_ack = 1; wrap_ok = 1; timed_out = 0;
    for (int t = 1; t <= 256; t++) begin
      req = 1; step(); req = 0; step();
      n = 0;
      while (cyc && n < 20) begin n++; step(); end
      if (n >= 20) timed_out = 1;
      if (count !== 8'(t)) wrap_ok = 0;
      if (t == 255) check("wrap_255", count, 8'd255);
    end
    check("wrap_no_timeout", timed_out, 0);
    check("wrap_sequence", wrap_ok, 1);
    check("wrap_zero", {count, err}, {8'd0, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
